// File: rtl/tree_deserializer.sv
// -----------------------------------------------------------------------------
// tree_deserializer
//
// Serial-to-parallel receive stage for the tree_serializer bit stream. Hunts
// for SYNC_PATTERN to establish word alignment, then reassembles consecutive
// INPUTS_NUM-bit words (LSB first) and presents each with a one-cycle strobe.
// A wrapping count of delivered words since the last lock is maintained.
//
// Ports:
//   CLK        in   bit-rate clock, one serial bit sampled per rising edge
//   RESET      in   asynchronous active-low reset
//   SERIAL_IN  in   serial data, LSB of each word first
//   REALIGN    in   synchronous request to drop lock and re-hunt
//   PAR_OUT    out  last completed data word (held until the next one)
//   PAR_VALID  out  one-cycle strobe marking a new PAR_OUT
//   LOCKED     out  high while word-aligned
//   FRAME_CNT  out  words delivered since lock, wrapping
// -----------------------------------------------------------------------------
module tree_deserializer #(
  parameter int unsigned           INPUTS_NUM   = 8,
  parameter logic [INPUTS_NUM-1:0] SYNC_PATTERN = INPUTS_NUM'(8'hA5),
  parameter int unsigned           CNT_W        = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  SERIAL_IN,
  input  logic                  REALIGN,
  output logic [INPUTS_NUM-1:0] PAR_OUT,
  output logic                  PAR_VALID,
  output logic                  LOCKED,
  output logic [CNT_W-1:0]      FRAME_CNT
);

  localparam int unsigned BW = $clog2(INPUTS_NUM);

  typedef enum logic {
    ST_HUNT,
    ST_LOCKED
  } state_t;

  state_t                  state, state_next;
  logic [INPUTS_NUM-1:0]   sr, sr_next;
  logic [BW-1:0]           bcnt, bcnt_next;
  logic [INPUTS_NUM-1:0]   par_out_next;
  logic                    par_valid_next;
  logic [CNT_W-1:0]        frame_cnt_next;

  // The shift register runs in every state so a re-hunt after REALIGN can
  // match on the very next edge.
  assign sr_next = {SERIAL_IN, sr[INPUTS_NUM-1:1]};

  // NOTE: every signal assigned here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next     = state;
    bcnt_next      = bcnt;
    par_out_next   = PAR_OUT;
    par_valid_next = 1'b0;
    frame_cnt_next = FRAME_CNT;

    if (REALIGN) begin
      // Realign wins over both a sync match and a word completion; the
      // partial word is dropped and PAR_OUT / FRAME_CNT hold.
      state_next = ST_HUNT;
      bcnt_next  = '0;
    end else begin
      unique case (state)
        ST_HUNT: begin
          if (sr_next == SYNC_PATTERN) begin
            state_next     = ST_LOCKED;
            bcnt_next      = '0;
            frame_cnt_next = '0;
          end
        end
        ST_LOCKED: begin
          // bcnt wraps naturally because INPUTS_NUM is a power of two.
          bcnt_next = bcnt + BW'(1);
          if (bcnt == BW'(INPUTS_NUM - 1)) begin
            par_out_next   = sr_next;
            par_valid_next = 1'b1;
            frame_cnt_next = FRAME_CNT + CNT_W'(1);
          end
        end
        default: state_next = ST_HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ST_HUNT;
      sr        <= '0;
      bcnt      <= '0;
      PAR_OUT   <= '0;
      PAR_VALID <= 1'b0;
      FRAME_CNT <= '0;
    end else begin
      state     <= state_next;
      sr        <= sr_next;
      bcnt      <= bcnt_next;
      PAR_OUT   <= par_out_next;
      PAR_VALID <= par_valid_next;
      FRAME_CNT <= frame_cnt_next;
    end
  end

  // Decoded straight from the state flop, so it is glitch-free and registered.
  assign LOCKED = (state == ST_LOCKED);

endmodule

// File: tb/tb_tree_deserializer.sv
// -----------------------------------------------------------------------------
// tb_tree_deserializer
//
// Self-checking bench for tree_deserializer (INPUTS_NUM=8, SYNC=8'hA5,
// CNT_W=4 so the counter wrap is reachable). A stream-level reference model
// keeps the last INPUTS_NUM received bits and the lock/word position; each
// expected word is pushed into a scoreboard and a negedge monitor pops and
// compares whenever PAR_VALID appears.
// -----------------------------------------------------------------------------
module tb_tree_deserializer;

  localparam int         N    = 8;
  localparam int         CW   = 4;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          serial_in;
  logic          realign;
  logic [N-1:0]  par_out;
  logic          par_valid;
  logic          locked;
  logic [CW-1:0] frame_cnt;

  tree_deserializer #(
    .INPUTS_NUM  (N),
    .SYNC_PATTERN(SYNC),
    .CNT_W       (CW)
  ) dut (
    .CLK      (clk),
    .RESET    (rst_n),
    .SERIAL_IN(serial_in),
    .REALIGN  (realign),
    .PAR_OUT  (par_out),
    .PAR_VALID(par_valid),
    .LOCKED   (locked),
    .FRAME_CNT(frame_cnt)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  typedef struct {
    logic [N-1:0]  data;
    logic [CW-1:0] cnt;
    int            at_edge;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // ---------------- reference model (stream level) ----------------
  bit            hist[$];   // last N received bits, oldest first
  bit            m_locked;
  int            m_phase;   // bits of the current word received so far
  logic [CW-1:0] m_cnt;
  logic [N-1:0]  m_par;

  task automatic model_reset();
    hist.delete();
    repeat (N) hist.push_back(1'b0);
    m_locked = 1'b0;
    m_phase  = 0;
    m_cnt    = '0;
    m_par    = '0;
    sb.delete();
  endtask

  function automatic logic [N-1:0] window();
    logic [N-1:0] w;
    for (int k = 0; k < N; k++) w[k] = hist[k];
    return w;
  endfunction

  task automatic model_step(input bit b, input bit r);
    logic [N-1:0] w;
    hist.push_back(b);
    void'(hist.pop_front());
    w = window();
    if (r) begin
      m_locked = 1'b0;
      m_phase  = 0;
    end else if (!m_locked) begin
      if (w == SYNC) begin
        m_locked = 1'b1;
        m_phase  = 0;
        m_cnt    = '0;
      end
    end else begin
      m_phase++;
      if (m_phase == N) begin
        m_phase = 0;
        m_cnt   = m_cnt + 1'b1;
        m_par   = w;
        sb.push_back('{data: w, cnt: m_cnt, at_edge: edge_cnt});
      end
    end
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sb.size() > 0 && sb[0].at_edge <= edge_cnt) begin
        mon_e = sb.pop_front();
        check("par_valid strobe", 32'(par_valid), 32'd1);
        if (par_valid === 1'b1) begin
          check("par_out word", 32'(par_out), 32'(mon_e.data));
          check("frame_cnt at word", 32'(frame_cnt), 32'(mon_e.cnt));
        end
      end else if (par_valid !== 1'b0) begin
        check("spurious par_valid", 32'(par_valid), 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  // Called once per cycle; returns 1 time unit after the sampling edge.
  task automatic send_bit(input bit b, input bit r);
    @(negedge clk);
    serial_in = b;
    realign   = r;
    @(posedge clk);
    #1;
    model_step(b, r);
    check("locked", 32'(locked), 32'(m_locked));
    check("par_out hold", 32'(par_out), 32'(m_par));
    check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
  endtask

  // rl_idx: bit index at which REALIGN is raised, -1 for none.
  task automatic send_word(input logic [N-1:0] w, input int rl_idx = -1);
    for (int i = 0; i < N; i++) send_bit(w[i], i == rl_idx);
  endtask

  task automatic relock();
    send_bit(1'b0, 1'b1);
    repeat (N) send_bit(1'b0, 1'b0);
    send_word(SYNC);
  endtask

  // Must follow a send_bit: asserts reset mid-cycle, away from both edges.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("reset locked", 32'(locked), 32'd0);
    check("reset par_valid", 32'(par_valid), 32'd0);
    check("reset par_out", 32'(par_out), 32'd0);
    check("reset frame_cnt", 32'(frame_cnt), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (edge %0d)", edge_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] w;
    rst_n     = 1'b0;
    serial_in = 1'b0;
    realign   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("init locked", 32'(locked), 32'd0);
    check("init par_valid", 32'(par_valid), 32'd0);
    check("init par_out", 32'(par_out), 32'd0);
    check("init frame_cnt", 32'(frame_cnt), 32'd0);
    #1;
    rst_n = 1'b1;

    // Basic lock and word.
    send_word(SYNC);
    check("basic locked", 32'(locked), 32'd1);
    send_word(8'h3C);
    check("basic par_out", 32'(par_out), 32'h3C);
    check("basic frame_cnt", 32'(frame_cnt), 32'd1);

    // Sync word delivered as data while locked.
    send_word(SYNC);
    check("sync-as-data par_out", 32'(par_out), 32'hA5);
    check("sync-as-data locked", 32'(locked), 32'd1);
    send_word(8'h5A);

    // Mid-stream reset with random bits, then misaligned start.
    repeat (5) send_bit(1'($urandom), 1'b0);
    do_reset();
    repeat (12) send_bit(1'($urandom_range(0, 1)) & 1'b0, 1'b0);
    check("no lock without sync", 32'(locked), 32'd0);
    do_reset();
    repeat (3) send_bit(1'b0, 1'b0);
    send_word(SYNC);
    send_word(8'hFF);
    send_word(8'h00);
    send_word(8'h81);
    check("misaligned par_out", 32'(par_out), 32'h81);
    check("misaligned frame_cnt", 32'(frame_cnt), 32'd3);

    // Realign collides with word completion.
    send_word(8'h5A, N - 1);
    check("collision locked", 32'(locked), 32'd0);
    check("collision par_out kept", 32'(par_out), 32'h81);
    check("collision frame_cnt kept", 32'(frame_cnt), 32'd3);
    repeat (N) send_bit(1'b0, 1'b0);
    send_word(SYNC);
    check("relock frame_cnt cleared", 32'(frame_cnt), 32'd0);
    send_word(8'h42);
    check("relock par_out", 32'(par_out), 32'h42);

    // Counter wrap: 17 words on a 4-bit counter ends at 1.
    relock();
    for (int i = 0; i < 17; i++) send_word(8'($urandom));
    check("wrap frame_cnt", 32'(frame_cnt), 32'd1);

    // Randomised mix of junk, sync words, data, realigns and resets.
    for (int it = 0; it < 200; it++) begin
      w = 8'($urandom);
      case ($urandom_range(0, 5))
        0:       repeat ($urandom_range(1, 12)) send_bit(1'($urandom), 1'b0);
        1:       send_word(SYNC);
        2, 3:    send_word(w);
        4:       send_word(w, int'($urandom_range(0, N - 1)));
        default: if ($urandom_range(0, 19) == 0) do_reset(); else send_word(w);
      endcase
    end

    repeat (N + 2) send_bit(1'b0, 1'b0);
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tree_deserializer.md
# tree_deserializer

Serial-to-parallel receive stage that sits directly downstream of `tree_serializer` and consumes its `SERIAL_OUT` bit stream. It hunts for a programmable sync word to establish word alignment, then reassembles consecutive `INPUTS_NUM`-bit words and presents each one with a single-cycle valid strobe. It also keeps a wrapping count of delivered words. The whole block runs in the single bit-rate clock domain.

## Interface
- `INPUTS_NUM`, 8: word width in bits; must match the upstream serializer; power of two, minimum 2.
- `SYNC_PATTERN`, 8'hA5: `INPUTS_NUM`-bit alignment word; must not be all-zeros.
- `CNT_W`, 16: width of `FRAME_CNT`.
- `CLK` input 1: bit-rate clock; one serial bit is sampled per rising edge.
- `RESET` input 1: asynchronous, active-low reset.
- `SERIAL_IN` input 1: serial data, least-significant bit first (`PAR_IN[0]` of the upstream word arrives first).
- `REALIGN` input 1: synchronous request to drop lock and re-hunt.
- `PAR_OUT` output `INPUTS_NUM`: last completed data word.
- `PAR_VALID` output 1: one-cycle strobe marking a new `PAR_OUT`.
- `LOCKED` output 1: high while word-aligned.
- `FRAME_CNT` output `CNT_W`: number of words delivered since lock, wrapping.

## Operation
- Shift register `sr`, `INPUTS_NUM` bits, updated every edge as `sr_next = {SERIAL_IN, sr[N-1:1]}`. It shifts in every state.
- Bit counter `bcnt`, $clog2(`INPUTS_NUM`) bits, used only in LOCKED.
- **State HUNT** (reset state):
  - Each edge, compare `sr_next` with `SYNC_PATTERN`.
  - On a match: go to LOCKED, set `bcnt` = 0 and `FRAME_CNT` = 0.
  - The sync word itself is never emitted.
- **State LOCKED**:
  - Each edge, `bcnt` increments modulo `INPUTS_NUM`.
  - At the edge where `bcnt` == `INPUTS_NUM`-1: load `PAR_OUT` <= `sr_next`, pulse `PAR_VALID`, and increment `FRAME_CNT`. `FRAME_CNT` wraps from all-ones to 0.
  - Received words equal to `SYNC_PATTERN` are delivered as ordinary data; there is no re-hunt on them.
- **REALIGN** high at an edge, in either state:
  - Next state is HUNT, `LOCKED` drops, `bcnt` is cleared, and no `PAR_VALID` is issued.
  - Any partially received word is discarded.
  - `PAR_OUT` and `FRAME_CNT` hold their values.
  - The shift register keeps shifting, and the sync comparison at that edge is ignored.
- **Simultaneous events:** `REALIGN` beats both a sync match and word completion at the same edge.
- **Reset, asynchronous at any time:** state HUNT; `sr`, `bcnt`, `PAR_OUT` = 0; `PAR_VALID` = 0; `LOCKED` = 0; `FRAME_CNT` = 0.
  - Deassertion mid-stream restarts the sync hunt from an empty (all-zero) shift register.
- `LOCKED` is a registered output and equals (state == LOCKED).

## Timing
- **Lock latency:** `LOCKED` rises in the cycle after the edge that samples the last sync bit.
- **Word latency:** `PAR_VALID` is high for exactly one cycle, the cycle after the edge that samples the word's last bit.
  - `PAR_OUT` and `FRAME_CNT` update at that same edge.
  - `PAR_OUT` then holds until the next word.
- **Steady-state cadence:**
  - The first `PAR_VALID` comes `INPUTS_NUM` edges after the lock edge.
  - After that, `PAR_VALID` pulses exactly once every `INPUTS_NUM` cycles, never in two adjacent cycles.
- **REALIGN:** takes effect at the sampling edge, so `LOCKED` is low in the following cycle.
  - The earliest re-lock is at that edge's successor, if `sr_next` then matches the pattern.
- There is no backpressure; the consumer must accept every strobe.

## Test plan
All scenarios use `INPUTS_NUM`=8 and `SYNC_PATTERN`=8'hA5.
- **Reset state:** assert `RESET` low mid-stream with random `SERIAL_IN` -> all outputs 0 asynchronously; `LOCKED` stays 0 until a full sync word follows deassertion.
- **Basic lock and word:** send sync bits 1,0,1,0,0,1,0,1, then 0x3C as 0,0,1,1,1,1,0,0 -> `LOCKED` high one cycle after the 8th sync bit; `PAR_VALID` one cycle after the 8th data bit with `PAR_OUT`=8'h3C and `FRAME_CNT`=1.
- **Misaligned start:** send 3 junk zero bits, then sync, then 0xFF, 0x00, 0x81 -> three `PAR_VALID` pulses 8 cycles apart carrying 8'hFF, 8'h00, 8'h81; `FRAME_CNT` reaches 3.
- **Sync word as data:** after lock, send 0xA5 as data -> delivered as `PAR_OUT`=8'hA5; `LOCKED` stays high and cadence is unchanged.
- **Realign collision:** assert `REALIGN` exactly on the edge completing a word -> no `PAR_VALID`, `LOCKED`=0 next cycle, `PAR_OUT` keeps the previous word; resending sync re-locks with `FRAME_CNT` cleared to 0.
- **Counter wrap:** with `CNT_W`=4, deliver 17 words -> `FRAME_CNT` goes 15, then 0, then 1, and `PAR_VALID` spacing stays 8 cycles throughout.
